reg_writeback: RTL and testbench
================================

# reg_writeback

Writeback sequencer that drives the write port of the 32×32 MIPS register file. It accepts writeback requests from two producers, the ALU result path and the memory load path, over valid/ready handshakes. It queues them in program order in a small buffer and retires at most one register write per cycle. It also answers a pending-write query so the decode stage can stall on read-after-write hazards.

## Interface
Parameters:
- WIDTH, 32, data width
- SEL_WIDTH, 5, register select width
- DEPTH, 4, queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  load result available
- mem_ready  out  1  load result accepted when mem_valid && mem_ready
- mem_reg  in  SEL_WIDTH  load destination register
- mem_data  in  WIDTH  load data
- alu_valid  in  1  ALU result available
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
- alu_reg  in  SEL_WIDTH  ALU destination register
- alu_data  in  WIDTH  ALU data
- write  out  1  register file write enable
- write_reg  out  SEL_WIDTH  register file write select
- write_data  out  WIDTH  register file write data
- pending  out  clog2(DEPTH)+1  entries currently queued
- query_reg  in  SEL_WIDTH  register probed by decode
- query_hit  out  1  write to query_reg still outstanding

## Operation
- FIFO of {reg, data} entries with head/tail pointers and a count.
- Ready rules are combinational from registered count and mem_valid, with free = DEPTH − count. There is no same-cycle credit from a dequeue.
  - mem_ready = (free ≥ 1).
  - alu_ready = (free ≥ 2) || (free ≥ 1 && !mem_valid).
- Both accepted in one cycle: the mem entry is enqueued first, because it belongs to the older instruction. The ALU entry goes into the next slot.
- Destination 0: the handshake completes normally, but the entry is discarded and never stored. Register 0 is never written.
- Drain: when count > 0 at a rising edge, pop the head and register it onto write/write_reg/write_data. Otherwise write = 0, and write_reg/write_data hold their last values.
- count_next = count + enqueued − dequeued. Simultaneous enqueue of 2 and dequeue of 1 is legal.
- Pointers wrap modulo DEPTH.
- pending equals count.
- query_hit = 1 when query_reg ≠ 0 and either condition holds:
  - any valid queued entry matches query_reg, or
  - write = 1 and write_reg == query_reg.
- query_hit is purely combinational.

## Timing
- Reset values: write 0, write_reg 0, write_data 0, pending 0, count and pointers 0.
  - Consequently mem_ready = 1 and alu_ready = 1 out of reset.
- Reset mid-operation discards all queued entries. write drops to 0 at the reset edge.
- Latency: a handshake at edge N on an empty queue produces write = 1 for exactly the cycle after edge N+1.
- Outputs are registered and stable for the full cycle. This lets the register file sample them on the falling edge.
- Throughput: one write per cycle. A full queue drains DEPTH entries in DEPTH consecutive cycles.
- Full: with count = DEPTH, both readies are 0. With count = DEPTH−1 and mem_valid = 1, alu_ready = 0.
- Same register targeted twice in the queue: both writes are issued in order, and the last one wins.

## Structure
- Shared package holds:
  - WIDTH and SEL_WIDTH constants
  - the wb_entry_t typedef {reg[SEL_WIDTH], data[WIDTH]}
  - a REG_ZERO constant
- Sub-module wb_fifo: DEPTH-entry buffer with 2 ordered write ports, 1 read port, count output and a parallel match output for query_hit.
- reg_writeback holds the ready logic, zero filtering and output register.

## Test plan
- Reset, then mem_valid with mem_reg 5, mem_data 0xDEADBEEF for one cycle.
  - Required: write = 1, write_reg 5, write_data 0xDEADBEEF exactly two edges later, for one cycle.
  - Required: pending goes 1 then 0.
- Same cycle: mem (reg 3, 0x11) and alu (reg 3, 0x22).
  - Required: writes issue on consecutive cycles, 0x11 then 0x22.
- alu_reg 0 with alu_valid.
  - Required: alu_ready = 1, pending stays 0, write never asserts.
- Hold both sources valid with no drain stall until full.
  - Required: pending never exceeds 4.
  - Required: alu_ready = 0 whenever count = 3 and mem_valid = 1.
  - Required: entry order is preserved across pointer wrap over 12 entries.
- Queue reg 9, set query_reg 9.
  - Required: query_hit = 1 through the cycle with write = 1, then 0.
  - Required: query_reg 0 always gives 0.
- Assert reset with 3 entries queued.
  - Required: next cycle write = 0, pending 0, both readies 1, and no stale writes afterward.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// Shared types and constants for the register-file writeback sequencer.
package reg_writeback_pkg;

    localparam int WIDTH     = 32;
    localparam int SEL_WIDTH = 5;

    localparam logic [SEL_WIDTH-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [SEL_WIDTH-1:0] dest;
        logic [WIDTH-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_wb_fifo.sv
// Writeback entry buffer: two ordered enqueue ports, one dequeue port,
// occupancy count and a parallel destination match across live entries.
module reg_writeback_wb_fifo
    import reg_writeback_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push0,
    input  wb_entry_t            entry0,
    input  logic                 push1,
    input  wb_entry_t            entry1,
    input  logic                 pop,
    output wb_entry_t            head,
    output logic [CW-1:0]        count,
    input  logic [SEL_WIDTH-1:0] query_reg,
    output logic                 match
);

    wb_entry_t     slots [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [PW-1:0] tail_next;
    logic [DEPTH-1:0] hit;

    // push1 is only ever raised together with push0, so it lands one slot later
    assign tail_next = tail_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push0) slots[tail_ptr]  <= entry0;
            if (push1) slots[tail_next] <= entry1;
            if (pop)   head_ptr <= head_ptr + PW'(1);
            tail_ptr <= tail_ptr + PW'(push0) + PW'(push1);
            count    <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    assign head = slots[head_ptr];

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PW-1:0] offset;
        assign offset = PW'(i) - head_ptr;
        assign hit[i] = ({1'b0, offset} < count) && (slots[i].dest == query_reg);
    end

    assign match = |hit;

endmodule

// File: rtl/reg_writeback.sv
// Writeback sequencer: accepts ALU and load results, queues them in program
// order and retires one register-file write per cycle.
module reg_writeback #(
    parameter int WIDTH     = reg_writeback_pkg::WIDTH,
    parameter int SEL_WIDTH = reg_writeback_pkg::SEL_WIDTH,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [SEL_WIDTH-1:0]   mem_reg,
    input  logic [WIDTH-1:0]       mem_data,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [SEL_WIDTH-1:0]   alu_reg,
    input  logic [WIDTH-1:0]       alu_data,
    output logic                   write,
    output logic [SEL_WIDTH-1:0]   write_reg,
    output logic [WIDTH-1:0]       write_data,
    output logic [$clog2(DEPTH):0] pending,
    input  logic [SEL_WIDTH-1:0]   query_reg,
    output logic                   query_hit
);
    import reg_writeback_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] ROOM2 = CW'(DEPTH - 2);

    logic [CW-1:0] count;
    logic          mem_keep;
    logic          alu_keep;
    logic          pop;
    logic          match;
    wb_entry_t     mem_entry;
    wb_entry_t     alu_entry;
    wb_entry_t     port0_entry;
    wb_entry_t     head;

    // No credit from the same-cycle dequeue: readies look only at registered count
    assign mem_ready = (count < FULL);
    assign alu_ready = (count <= ROOM2) || (mem_ready && !mem_valid);

    // Writes to register 0 complete the handshake but are dropped here
    assign mem_keep = mem_valid && mem_ready && (mem_reg != REG_ZERO);
    assign alu_keep = alu_valid && alu_ready && (alu_reg != REG_ZERO);

    assign mem_entry   = '{dest: mem_reg, data: mem_data};
    assign alu_entry   = '{dest: alu_reg, data: alu_data};
    assign port0_entry = mem_keep ? mem_entry : alu_entry;
    assign pop         = (count != '0);

    reg_writeback_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push0     (mem_keep || alu_keep),
        .entry0    (port0_entry),
        .push1     (mem_keep && alu_keep),
        .entry1    (alu_entry),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .query_reg (query_reg),
        .match     (match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            write      <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            write <= pop;
            if (pop) begin
                write_reg  <= head.dest;
                write_data <= head.data;
            end
        end
    end

    assign pending   = count;
    assign query_hit = (query_reg != REG_ZERO) &&
                       (match || (write && (write_reg == query_reg)));

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: vector table plus hand sequences,
// with a scoreboard queue matched against every register-file write.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, alu_valid;
    logic        mem_ready, alu_ready;
    logic [4:0]  mem_reg, alu_reg, write_reg, query_reg;
    logic [31:0] mem_data, alu_data, write_data;
    logic        write, query_hit;
    logic [2:0]  pending;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        emr;
        logic        ear;
        int          ep;
    } vec_t;

    vec_t vecs[12];

    reg_writeback dut (
        .clk        (clk),
        .reset      (reset),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_reg    (mem_reg),
        .mem_data   (mem_data),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .write      (write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .pending    (pending),
        .query_reg  (query_reg),
        .query_hit  (query_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every write seen by the register file must be the oldest expected one
    always @(negedge clk) begin
        if (write) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {27'd0, write_reg}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("write_reg", {27'd0, write_reg}, {27'd0, e.r});
                chk("write_data", write_data, e.d);
            end
        end
    end

    task automatic cycle(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic emr, input logic ear, input int ep);
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        #1;
        chk("mem_ready", {31'd0, mem_ready}, {31'd0, emr});
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, ear});
        chk("pending", 32'(pending), 32'(ep));
        if (mv && emr && mr != 5'd0) sb.push_back('{mr, md});
        if (av && ear && ar != 5'd0) sb.push_back('{ar, ad});
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic idle(input int ep);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, ep);
    endtask

    initial begin
        // both producers busy; alu held whenever it was refused
        vecs[0]  = '{1, 5'd1,  32'h100, 1, 5'd2,  32'h200, 1, 1, 0};
        vecs[1]  = '{1, 5'd3,  32'h101, 1, 5'd4,  32'h201, 1, 1, 2};
        vecs[2]  = '{1, 5'd5,  32'h102, 1, 5'd6,  32'h202, 1, 0, 3};
        vecs[3]  = '{0, 5'd0,  32'h0,   1, 5'd6,  32'h202, 1, 1, 3};
        vecs[4]  = '{1, 5'd7,  32'h103, 1, 5'd8,  32'h203, 1, 0, 3};
        vecs[5]  = '{0, 5'd0,  32'h0,   1, 5'd8,  32'h203, 1, 1, 3};
        vecs[6]  = '{1, 5'd9,  32'h104, 1, 5'd10, 32'h204, 1, 0, 3};
        vecs[7]  = '{0, 5'd0,  32'h0,   1, 5'd10, 32'h204, 1, 1, 3};
        vecs[8]  = '{1, 5'd11, 32'h105, 0, 5'd0,  32'h0,   1, 0, 3};
        vecs[9]  = '{1, 5'd12, 32'h106, 1, 5'd13, 32'h205, 1, 0, 3};
        vecs[10] = '{0, 5'd0,  32'h0,   1, 5'd13, 32'h205, 1, 1, 3};
        vecs[11] = '{1, 5'd14, 32'h107, 0, 5'd0,  32'h0,   1, 0, 3};

        reset = 1'b1;
        mem_valid = 0; alu_valid = 0;
        mem_reg = 0; alu_reg = 0; mem_data = 0; alu_data = 0; query_reg = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_write_reg", {27'd0, write_reg}, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        reset = 1'b0;

        // single load: write exactly two edges after the handshake
        cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 1, 1, 0);
        chk("lat_write_early", {31'd0, write}, 32'd0);
        idle(1);
        chk("lat_write", {31'd0, write}, 32'd1);
        chk("lat_write_reg", {27'd0, write_reg}, 32'd5);
        idle(0);
        chk("lat_write_once", {31'd0, write}, 32'd0);

        // mem and alu to the same register in one cycle: mem first
        cycle(1, 5'd3, 32'h11, 1, 5'd3, 32'h22, 1, 1, 0);
        idle(2);
        chk("pair_first", write_data, 32'h11);
        idle(1);
        chk("pair_second", write_data, 32'h22);
        idle(0);

        // register 0 is accepted and dropped
        cycle(0, 5'd0, 32'd0, 1, 5'd0, 32'hBAD, 1, 1, 0);
        idle(0);
        idle(0);
        chk("zero_no_write", {31'd0, write}, 32'd0);

        for (int i = 0; i < 12; i++)
            cycle(vecs[i].mv, vecs[i].mr, vecs[i].md, vecs[i].av, vecs[i].ar,
                  vecs[i].ad, vecs[i].emr, vecs[i].ear, vecs[i].ep);
        idle(3);
        idle(2);
        idle(1);
        idle(0);

        // pending-write query
        query_reg = 5'd9;
        #1;
        chk("qhit_empty", {31'd0, query_hit}, 32'd0);
        cycle(1, 5'd9, 32'h99, 0, 5'd0, 32'd0, 1, 1, 0);
        chk("qhit_queued", {31'd0, query_hit}, 32'd1);
        query_reg = 5'd0;
        #1;
        chk("qhit_reg0_queued", {31'd0, query_hit}, 32'd0);
        query_reg = 5'd9;
        idle(1);
        chk("qhit_writing", {31'd0, query_hit}, 32'd1);
        chk("qhit_write_on", {31'd0, write}, 32'd1);
        query_reg = 5'd0;
        #1;
        chk("qhit_reg0_writing", {31'd0, query_hit}, 32'd0);
        query_reg = 5'd9;
        idle(0);
        chk("qhit_done", {31'd0, query_hit}, 32'd0);
        query_reg = 5'd0;

        // reset with three entries queued
        cycle(1, 5'd20, 32'hA1, 1, 5'd21, 32'hA2, 1, 1, 0);
        cycle(1, 5'd22, 32'hA3, 1, 5'd23, 32'hA4, 1, 1, 2);
        chk("pre_reset_pending", 32'(pending), 32'd3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        chk("mid_rst_write", {31'd0, write}, 32'd0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        chk("mid_rst_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("mid_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        reset = 1'b0;
        repeat (4) idle(0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
